// File: rtl/raw8_pkg.sv
// Shared definitions for the RAW8 frame capture controller: FSM state encoding
// and the default counter width.
package raw8_pkg;

  localparam int CNT_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Rise/fall pulse detector for a level already in the local clock domain.
// The primed flag stops a level that is already high from counting as an edge after reset.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_d;
  logic primed;

  always_ff @(posedge clk) begin
    if (rst) begin
      din_d  <= 1'b0;
      primed <= 1'b0;
    end else begin
      din_d  <= din;
      primed <= 1'b1;
    end
  end

  assign rise = primed &  din & ~din_d;
  assign fall = primed & ~din &  din_d;

endmodule

// File: rtl/raw8_frame_ctrl.sv
// Frame/line capture controller for a RAW8 sensor stream: arms on request,
// captures whole frames, qualifies pixels and checks frame geometry.
module raw8_frame_ctrl
  import raw8_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             pixel_clk_i,
  input  logic             pixel_rst_i,
  input  logic             vsync_i,
  input  logic             hsync_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic             single_shot_i,
  input  logic [CNT_W-1:0] cfg_width_i,
  input  logic [CNT_W-1:0] cfg_height_i,
  input  logic             err_clr_i,
  output logic             busy_o,
  output logic             frame_start_o,
  output logic             frame_end_o,
  output logic             line_start_o,
  output logic             pix_en_o,
  output logic [CNT_W-1:0] pix_x_o,
  output logic [CNT_W-1:0] line_y_o,
  output logic             err_width_o,
  output logic             err_height_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_e           state;
  state_e           state_nx;
  logic             vs_rise, vs_fall, hs_rise, hs_fall;
  logic             start, capturing, line_end, stay_in_line;
  logic             width_bad, height_bad;
  logic [CNT_W-1:0] pix_cnt, cfg_w_q, cfg_h_q, lines_eff;

  sync_edge_det u_vs_edge (
    .clk  (pixel_clk_i),
    .rst  (pixel_rst_i),
    .din  (vsync_i),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  sync_edge_det u_hs_edge (
    .clk  (pixel_clk_i),
    .rst  (pixel_rst_i),
    .din  (hsync_i),
    .rise (hs_rise),
    .fall (hs_fall)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (arm_i)   state_nx = ST_ARMED;
      ST_ARMED:   if (vs_rise) state_nx = ST_CAPTURE;
      ST_CAPTURE: if (vs_fall) state_nx = ST_DONE;
      ST_DONE:    state_nx = single_shot_i ? ST_IDLE : ST_ARMED;
      default:    state_nx = ST_IDLE;
    endcase
    if (abort_i) state_nx = ST_IDLE;
  end

  // pix_en_o doubles as the "inside a captured line" flag; a line cut by the
  // frame end or an abort is simply dropped without a width check.
  assign start        = (state == ST_ARMED) & vs_rise & ~abort_i;
  assign capturing    = (state == ST_CAPTURE) & ~abort_i;
  assign stay_in_line = capturing & ~vs_fall & hsync_i & (hs_rise | pix_en_o);
  assign line_end     = capturing & pix_en_o & hs_fall;
  assign lines_eff    = line_end ? sat_inc(line_y_o) : line_y_o;
  assign width_bad    = line_end & (pix_cnt != cfg_w_q);
  assign height_bad   = capturing & vs_fall & (lines_eff != cfg_h_q);

  always_ff @(posedge pixel_clk_i) begin
    if (pixel_rst_i) begin
      state         <= ST_IDLE;
      busy_o        <= 1'b0;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
      line_start_o  <= 1'b0;
      pix_en_o      <= 1'b0;
      pix_x_o       <= '0;
      line_y_o      <= '0;
      pix_cnt       <= '0;
      cfg_w_q       <= '0;
      cfg_h_q       <= '0;
      err_width_o   <= 1'b0;
      err_height_o  <= 1'b0;
    end else begin
      state         <= state_nx;
      busy_o        <= (state_nx == ST_ARMED) || (state_nx == ST_CAPTURE);
      frame_start_o <= start;
      frame_end_o   <= capturing & vs_fall;
      pix_en_o      <= stay_in_line;
      line_start_o  <= stay_in_line & hs_rise;

      if (start) begin
        line_y_o <= '0;
        cfg_w_q  <= cfg_width_i;
        cfg_h_q  <= cfg_height_i;
      end

      if (stay_in_line) begin
        if (hs_rise) begin
          pix_x_o <= '0;
          pix_cnt <= CNT_W'(1);
        end else begin
          pix_x_o <= sat_inc(pix_x_o);
          pix_cnt <= sat_inc(pix_cnt);
        end
      end

      if (line_end) line_y_o <= lines_eff;

      // A new error outranks a simultaneous clear.
      if (width_bad)      err_width_o <= 1'b1;
      else if (err_clr_i) err_width_o <= 1'b0;

      if (height_bad)     err_height_o <= 1'b1;
      else if (err_clr_i) err_height_o <= 1'b0;
    end
  end

endmodule

// File: doc/raw8_frame_ctrl.md
RAW8_FRAME_CTRL -- requirements
Module: raw8_frame_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 12, width of pixel/line counters and size config.
REQ-002 SHALL have port pixel_clk_i  in  1  sole clock.
REQ-003 SHALL have port pixel_rst_i  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port vsync_i  in  1  frame-valid level, already in pixel_clk_i domain.
REQ-005 SHALL have port hsync_i  in  1  line-valid level, already in pixel_clk_i domain.
REQ-006 SHALL have port arm_i  in  1  one-cycle request to capture from next frame start.
REQ-007 SHALL have port abort_i  in  1  one-cycle request to stop capture immediately.
REQ-008 SHALL have port single_shot_i  in  1  1: one frame then IDLE; 0: continuous.
REQ-009 SHALL have port cfg_width_i  in  CNT_W  expected pixels per line.
REQ-010 SHALL have port cfg_height_i  in  CNT_W  expected lines per frame.
REQ-011 SHALL have port err_clr_i  in  1  clears sticky error flags.
REQ-012 SHALL have port busy_o  out  1  state is ARMED or CAPTURE.
REQ-013 SHALL have port frame_start_o / frame_end_o / line_start_o  out  1 each  one-cycle pulses.
REQ-014 SHALL have port pix_en_o  out  1  pixel qualifier during captured lines.
REQ-015 SHALL have port pix_x_o / line_y_o  out  CNT_W each  0-based pixel and line index.
REQ-016 SHALL have port err_width_o / err_height_o  out  1 each  sticky size-mismatch flags.

Function
REQ-017 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-018 SHALL detect edges from the current input vs. its one-cycle-delayed sample; all outputs registered.
REQ-019 IDLE->ARMED on arm_i; arm_i ignored in ARMED, CAPTURE, DONE.
REQ-020 ARMED->CAPTURE only on vsync rising edge; if vsync_i is already high when armed, wait for the next rising edge (no partial frames).
REQ-021 frame_start_o SHALL pulse in the cycle after the vsync rising edge is sampled; line_y_o is cleared to 0 at the same time.
REQ-022 In CAPTURE, pix_en_o = hsync_i delayed one cycle; pix_x_o SHALL be 0 on the first pix_en_o cycle of each line and increment per pix_en_o, saturating at 2^CNT_W-1.
REQ-023 line_start_o SHALL pulse with the first pix_en_o of each line.
REQ-024 On hsync falling edge in CAPTURE, the line counter SHALL increment (saturating), and err_width_o SHALL set if the pixel count != cfg_width_i.
REQ-025 On vsync falling edge in CAPTURE: CAPTURE->DONE; frame_end_o pulses the next cycle; err_height_o sets if the line count != cfg_height_i.
REQ-026 Simultaneous hsync and vsync falling edges: the width check and line increment SHALL apply first, and the height check SHALL include that line.
REQ-027 DONE lasts one cycle, then goes to IDLE if single_shot_i=1, else ARMED.
REQ-028 abort_i SHALL force IDLE from any state next cycle, with no frame_end_o, no error update, and pix_en_o low.
REQ-029 hsync activity outside CAPTURE SHALL produce no pix_en_o, line_start_o, or counter change.
REQ-030 err_clr_i coincident with a new error: the error SHALL win (flag stays set).
REQ-031 Counters and config SHALL be compared at CNT_W width, unsigned; config is sampled at frame start and held for the frame.

Reset
REQ-032 On pixel_rst_i: state IDLE; all pulses, pix_en_o, busy_o, errors = 0; counters and edge-delay registers = 0.
REQ-033 Reset mid-frame SHALL abandon the frame without frame_end_o; after reset release, a vsync already high SHALL NOT count as a rising edge.

Structure
REQ-034 Package raw8_pkg SHALL hold the state enum and the CNT_W default constant.
REQ-035 SHALL instantiate sub-module sync_edge_det (rise/fall pulse detector, synchronous reset) once each for vsync_i and hsync_i.

Verification
REQ-036 Test 1: arm, frame of 4 lines x 8 px (cfg 8/4), single_shot=1 -> one frame_start_o, 32 pix_en_o, pix_x_o 0..7, line_y_o 0..3, frame_end_o, no errors, returns to IDLE.
REQ-037 Test 2: arm while vsync_i is high mid-frame -> no output until the next rising edge, then a full capture.
REQ-038 Test 3: line of 7 px with cfg_width=8 -> err_width_o set; stays set until err_clr_i; err_clr_i coincident with a new error leaves it set.
REQ-039 Test 4: hsync and vsync fall on the same cycle, cfg_height=4, 4th line ends there -> err_height_o stays 0.
REQ-040 Test 5: abort_i on line 2 -> IDLE next cycle, pix_en_o low, no frame_end_o; continuous mode with 3 frames -> 3 start/end pairs.
REQ-041 Test 6: pixel_rst_i mid-line with vsync_i held high -> all outputs 0, no frame_start_o after release until vsync toggles low then high.
